// File: rtl/maverickone_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// maverickone_wb_arbiter_pkg
//   Shared constants and types for the writeback arbiter slice.
//   XLEN          : register data width
//   NUM_REGS      : number of architectural registers
//   REG_AW        : register address width
//   WB_NUM_SRC    : number of result sources (ALU, MUL/DIV, LSU, CSR)
//   WB_FIFO_DEPTH : entries per source FIFO
//   wb_req_t      : one completed result (destination register + data)
//   rr_next()     : round-robin successor of a source index
// ----------------------------------------------------------------------------
package maverickone_wb_arbiter_pkg;

  localparam int XLEN          = 64;
  localparam int NUM_REGS      = 64;
  localparam int REG_AW        = $clog2(NUM_REGS);
  localparam int WB_NUM_SRC    = 4;
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/maverickone_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// maverickone_wb_arbiter_if
//   Bundles the result-source handshake and the regfile write/unlock port.
//   Parameters: NS sources, AW register address bits, DW data bits.
//   Signals:
//     src_valid_i  [NS]        result valid per source
//     src_ready_o  [NS]        source FIFO can accept
//     src_addr_i   [NS][AW]    destination register per source
//     src_data_i   [NS][DW]    result data per source
//     wr_unlock_en_o           write/unlock strobe to the regfile
//     wr_unlock_addr_o [AW]    register to write and unlock
//     wr_unlock_data_o [DW]    write data
//     pending_o    [NS]        source FIFO non-empty
//   Modports: master = execution units / regfile side, slave = arbiter.
// ----------------------------------------------------------------------------
interface maverickone_wb_arbiter_if
  import maverickone_wb_arbiter_pkg::*;
#(
  parameter int NS = WB_NUM_SRC,
  parameter int AW = REG_AW,
  parameter int DW = XLEN
);

  logic [NS-1:0]         src_valid_i;
  logic [NS-1:0]         src_ready_o;
  logic [NS-1:0][AW-1:0] src_addr_i;
  logic [NS-1:0][DW-1:0] src_data_i;
  logic                  wr_unlock_en_o;
  logic [AW-1:0]         wr_unlock_addr_o;
  logic [DW-1:0]         wr_unlock_data_o;
  logic [NS-1:0]         pending_o;

  modport master (
    output src_valid_i, src_addr_i, src_data_i,
    input  src_ready_o, wr_unlock_en_o, wr_unlock_addr_o, wr_unlock_data_o,
           pending_o
  );

  modport slave (
    input  src_valid_i, src_addr_i, src_data_i,
    output src_ready_o, wr_unlock_en_o, wr_unlock_addr_o, wr_unlock_data_o,
           pending_o
  );

endinterface

// File: rtl/maverickone_wb_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// maverickone_wb_arbiter_fifo
//   Small per-source result FIFO. DEPTH must be a power of two >= 2 so the
//   pointers wrap naturally.
//   Ports:
//     clk_i    clock, rising edge
//     arst_i   asynchronous active-high reset (pointers and count only)
//     push_i   store din_i (caller guarantees not full)
//     pop_i    drop the head (caller guarantees not empty)
//     din_i    result to store
//     head_o   oldest stored result (valid when count_o != 0)
//     count_o  number of stored results, 0..DEPTH
// ----------------------------------------------------------------------------
module maverickone_wb_arbiter_fifo
  import maverickone_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_req_t                      din_i,
  output wb_req_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries data only; emptiness is tracked by count_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/maverickone_wb_arbiter.sv
// ----------------------------------------------------------------------------
// maverickone_wb_arbiter
//   Writeback-side initiator of the regfile unlock/write port. Each result
//   source feeds its own FIFO; one FIFO head per cycle is chosen round-robin
//   and driven onto wr_unlock_*, which writes rd and clears its lock.
//   Results addressed to x0 are accepted and dropped.
//   Ports:
//     clk_i   clock, rising edge
//     arst_i  asynchronous active-high reset; discards all buffered results
//     bus     maverickone_wb_arbiter_if.slave (source handshake, regfile port,
//             pending status)
//   Optional feature (macro MAVERICKONE_WB_BYPASS_EN): a source with an empty
//   FIFO presenting a valid non-x0 result competes in the same cycle with its
//   input as head; if granted the result goes straight to the regfile.
// ----------------------------------------------------------------------------
module maverickone_wb_arbiter
  import maverickone_wb_arbiter_pkg::*;
#(
  parameter int NS    = WB_NUM_SRC,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  maverickone_wb_arbiter_if.slave    bus
);

  localparam int NR = NUM_REGS;
  localparam int DW = XLEN;
  localparam int AW = $clog2(NR);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NS > 1) ? $clog2(NS) : 1;

  wb_req_t       head   [NS];
  wb_req_t       cand   [NS];
  logic [CW-1:0] count  [NS];
  logic [NS-1:0] nonempty;
  logic [NS-1:0] ready;
  logic [NS-1:0] byp;
  logic [NS-1:0] req;
  logic [NS-1:0] push;
  logic [NS-1:0] pop;
  logic [NS-1:0] gnt_oh;
  logic [RW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [RW-1:0] rr_ptr_q;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  // Per-source status and arbitration candidates. Ready looks only at the
  // registered count, so a full FIFO popping this cycle still refuses.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    byp      = '0;
    for (int s = 0; s < NS; s++) begin
      nonempty[s] = (count[s] != '0);
      ready[s]    = !arst_i && (count[s] != CW'(DEPTH));
`ifdef MAVERICKONE_WB_BYPASS_EN
      byp[s]      = !arst_i && !nonempty[s] && bus.src_valid_i[s] &&
                    (bus.src_addr_i[s] != '0);
`else
      byp[s]      = 1'b0;
`endif
      cand[s].addr = bus.src_addr_i[s];
      cand[s].data = bus.src_data_i[s];
      if (nonempty[s]) cand[s] = head[s];
    end
    req = nonempty | byp;
  end

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NS) idx = idx - NS;
      if (!gnt_vld && req[idx]) begin
        gnt_vld     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = RW'(idx);
      end
    end
  end

  // FIFO control: a granted bypass candidate is written straight through and
  // never stored; x0 results are accepted but dropped.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int s = 0; s < NS; s++) begin
      pop[s]  = gnt_oh[s] && nonempty[s];
      push[s] = bus.src_valid_i[s] && ready[s] && (bus.src_addr_i[s] != '0) &&
                !(byp[s] && gnt_oh[s]);
    end
  end

  always_comb begin
    out_addr = '0;
    out_data = '0;
    if (gnt_vld) begin
      out_addr = cand[gnt_idx].addr;
      out_data = cand[gnt_idx].data;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_ptr_q <= '0;
    end else if (gnt_vld) begin
      rr_ptr_q <= RW'(rr_next(int'(gnt_idx), NS));
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_src
    wb_req_t din;
    assign din.addr = bus.src_addr_i[s];
    assign din.data = bus.src_data_i[s];

    maverickone_wb_arbiter_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .push_i  (push[s]),
      .pop_i   (pop[s]),
      .din_i   (din),
      .head_o  (head[s]),
      .count_o (count[s])
    );
  end

  assign bus.src_ready_o      = ready;
  assign bus.pending_o        = nonempty;
  assign bus.wr_unlock_en_o   = gnt_vld;
  assign bus.wr_unlock_addr_o = out_addr;
  assign bus.wr_unlock_data_o = out_data;

endmodule

// File: tb/tb_maverickone_wb_arbiter.sv
module tb_maverickone_wb_arbiter;
  import maverickone_wb_arbiter_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 6;
  localparam int DW    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maverickone_wb_arbiter_if #(.NS(NS), .AW(AW), .DW(DW)) bus();

  maverickone_wb_arbiter #(.NS(NS), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one queue of {addr,data} per source plus a round-robin pointer.
  logic [AW+DW-1:0] q [NS][$];
  int               rr = 0;
  logic [NS-1:0]    fired = '0;
  logic [NS-1:0]    m_ready;

  logic             obs_en;
  logic [AW-1:0]    obs_addr;
  logic [DW-1:0]    obs_data;
  logic [NS-1:0]    obs_ready;
  logic [NS-1:0]    obs_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.src_valid_i[s] = v;
    bus.src_addr_i[s]  = a;
    bus.src_data_i[s]  = d;
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++) set_src(s, 1'b0, '0, '0);
  endtask

  // One clock: check DUT against the model at the falling edge, then advance
  // the model as the rising edge will.
  task automatic cycle();
    logic [NS-1:0]    req;
    logic [NS-1:0]    pend;
    logic [AW+DW-1:0] hd [NS];
    int               sz [NS];
    int               g;
    int               cidx;
    bit               found;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_data;
    @(negedge clk);
    for (int s = 0; s < NS; s++) begin
      sz[s]      = q[s].size();
      m_ready[s] = !rst && (sz[s] != DEPTH);
      pend[s]    = (sz[s] != 0);
      req[s]     = pend[s];
      hd[s]      = {bus.src_addr_i[s], bus.src_data_i[s]};
      if (sz[s] != 0) hd[s] = q[s][0];
`ifdef MAVERICKONE_WB_BYPASS_EN
      if (!rst && sz[s] == 0 && bus.src_valid_i[s] && bus.src_addr_i[s] != '0) req[s] = 1'b1;
`endif
    end
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NS; k++) begin
      cidx = (rr + k) % NS;
      if (!found && req[cidx]) begin
        found = 1'b1;
        g     = cidx;
      end
    end
    e_addr = '0;
    e_data = '0;
    if (found) {e_addr, e_data} = hd[g];
    obs_en    = bus.wr_unlock_en_o;
    obs_addr  = bus.wr_unlock_addr_o;
    obs_data  = bus.wr_unlock_data_o;
    obs_ready = bus.src_ready_o;
    obs_pend  = bus.pending_o;
    chk("ready",   64'(obs_ready), 64'(m_ready));
    chk("pending", 64'(obs_pend),  64'(pend));
    chk("wr_en",   64'(obs_en),    64'(found));
    chk("wr_addr", 64'(obs_addr),  64'(e_addr));
    chk("wr_data", obs_data,       e_data);
    for (int s = 0; s < NS; s++) fired[s] = bus.src_valid_i[s] && m_ready[s];
    if (found && sz[g] != 0) void'(q[g].pop_front());
    for (int s = 0; s < NS; s++) begin
      if (fired[s] && bus.src_addr_i[s] != '0 && !(found && g == s && sz[s] == 0))
        q[s].push_back({bus.src_addr_i[s], bus.src_data_i[s]});
    end
    if (found) rr = (g + 1) % NS;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("rst_pending_now", 64'(bus.pending_o),        64'd0);
    chk("rst_ready_now",   64'(bus.src_ready_o),      64'd0);
    chk("rst_en_now",      64'(bus.wr_unlock_en_o),   64'd0);
    chk("rst_addr_now",    64'(bus.wr_unlock_addr_o), 64'd0);
    chk("rst_data_now",    bus.wr_unlock_data_o,      64'd0);
    for (int s = 0; s < NS; s++) q[s].delete();
    rr    = 0;
    fired = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_pending", 64'(bus.pending_o),      64'd0);
      chk("rst_en",      64'(bus.wr_unlock_en_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int bp_idx;
    bit bp_low;
    clear_all();
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (2) cycle();

    // Contention: all four sources at once, rr starts at 0.
    for (int s = 0; s < NS; s++) set_src(s, 1'b1, AW'(s + 1), 64'hC0DE_0000 + 64'(s));
    cycle();
    clear_all();
`ifndef MAVERICKONE_WB_BYPASS_EN
    for (int k = 0; k < NS; k++) begin
      cycle();
      chk("cont_order", 64'(obs_addr), 64'(k + 1));
    end
    cycle();
    chk("cont_idle_en", 64'(obs_en), 64'd0);
    set_src(0, 1'b1, AW'(1), 64'h11);
    set_src(2, 1'b1, AW'(3), 64'h33);
    cycle();
    clear_all();
    cycle();
    chk("pair_first",  64'(obs_addr), 64'd1);
    cycle();
    chk("pair_second", 64'(obs_addr), 64'd3);

    // Single source, one-cycle latency.
    set_src(0, 1'b1, AW'(5), 64'hDEAD_BEEF);
    cycle();
    clear_all();
    cycle();
    chk("single_en",   64'(obs_en),   64'd1);
    chk("single_addr", 64'(obs_addr), 64'd5);
    chk("single_data", obs_data,      64'hDEAD_BEEF);
    cycle();
    chk("single_done", 64'(obs_en),   64'd0);
`else
    repeat (6) cycle();
`endif

    // Mid-stream reset discards buffered results.
    for (int s = 0; s < NS; s++) set_src(s, 1'b1, AW'(s + 40), 64'hBAD0 + 64'(s));
    cycle();
    do_reset(3);
    clear_all();
    repeat (3) cycle();

    // Backpressure on source 1 while the others keep the arbiter busy.
    bp_idx = 0;
    bp_low = 1'b0;
    for (int c = 0; c < 16; c++) begin
      for (int s = 0; s < NS; s++) begin
        if (s != 1 && (!bus.src_valid_i[s] || fired[s]))
          set_src(s, 1'b1, AW'($urandom_range(1, 63)), {$urandom, $urandom});
      end
      if (bp_idx < 3) set_src(1, 1'b1, AW'(10 + bp_idx), 64'hB000 + 64'(bp_idx));
      else            set_src(1, 1'b0, '0, '0);
      cycle();
      if (!obs_ready[1]) bp_low = 1'b1;
      if (fired[1]) bp_idx++;
    end
    chk("bp_ready_low_seen", 64'(bp_low), 64'd1);
    chk("bp_all_sent",       64'(bp_idx), 64'd3);
    clear_all();
    repeat (12) cycle();

    // x0 results are accepted and dropped.
    set_src(3, 1'b1, '0, 64'h1234);
    cycle();
    chk("x0_ready", 64'(obs_ready[3]), 64'd1);
    clear_all();
    cycle();
    chk("x0_no_en",   64'(obs_en),      64'd0);
    chk("x0_no_pend", 64'(obs_pend[3]), 64'd0);

`ifdef MAVERICKONE_WB_BYPASS_EN
    set_src(2, 1'b1, AW'(7), 64'h7777);
    cycle();
    chk("byp_en",   64'(obs_en),   64'd1);
    chk("byp_addr", 64'(obs_addr), 64'd7);
    clear_all();
    cycle();
    chk("byp_not_stored", 64'(obs_pend[2]), 64'd0);
`endif

    // Randomized traffic with the hold-while-stalled source rule.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset(3);
        clear_all();
      end
      for (int s = 0; s < NS; s++) begin
        if (!(bus.src_valid_i[s] && !fired[s])) begin
          set_src(s, logic'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 63)),
                  {$urandom, $urandom});
        end
      end
      cycle();
    end
    clear_all();
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maverickone_wb_arbiter.md
Name: maverickOne_wb_arbiter

Overview:
- Writeback-side initiator of the register file's unlock/write port.
- Collects completed results (rd address and data) from several execution units, buffers each unit in a small FIFO, and picks one result per cycle by round-robin.
- The chosen result drives the regfile's wr_unlock address/data/enable, which writes rd and clears its lock in one cycle.
- Sits between the execution units and the regfile, opposite the issue stage that sets the locks.

Parameters:
- NS, default maverickOne_pkg::WB_NUM_SRC (4), number of result sources (ALU, MUL/DIV, LSU, CSR).
- DEPTH, default 2, entries per source FIFO; power of two, at least 2.
- NR, default maverickOne_pkg::NUM_REGS (64), number of registers. Localparam.
- DW, default maverickOne_pkg::XLEN (64), data width. Localparam.
- AW, default $clog2(NR), register address width. Localparam.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_i  input  1  reset, asynchronous, active-high.
- src_valid_i  input  NS  result valid, one bit per source.
- src_ready_o  output  NS  source FIFO can accept.
- src_addr_i  input  NS x AW  destination register per source.
- src_data_i  input  NS x DW  result data per source.
- wr_unlock_en_o  output  1  write/unlock strobe to the regfile.
- wr_unlock_addr_o  output  AW  register to write and unlock.
- wr_unlock_data_o  output  DW  write data.
- pending_o  output  NS  source FIFO non-empty (pipeline-drain status).

Behaviour:
- Reset: while arst_i=1, all FIFO pointers and counts are 0, rr_ptr=0, and pending_o='0. wr_unlock_en_o=0, wr_unlock_addr_o='0, wr_unlock_data_o='0, src_ready_o='0.
  - Asserting reset mid-operation discards all buffered results immediately.
  - The first accept happens at the first rising edge after deassertion.
- Handshake:
  - A transfer on source s occurs at a rising edge where src_valid_i[s] and src_ready_o[s] are both 1.
  - src_ready_o[s] = (count[s] != DEPTH). It depends only on registered count, with no comb path from pop. A full FIFO that pops in the same cycle still shows ready=0.
  - A source must hold addr/data stable while valid is 1 and ready is 0.
- x0 filter: a transfer with src_addr_i[s]==0 is accepted but not stored, and count is unchanged.
- FIFO: each source FIFO has wr_ptr, rd_ptr, and a count in 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- Arbitration:
  - Requests are req[s] = pending_o[s] = (count[s] != 0).
  - The grant goes to the first s with req[s]=1, searching rr_ptr, rr_ptr+1, ... modulo NS.
  - On a grant, that FIFO pops at the edge and rr_ptr <= (grant+1) mod NS. With no request, rr_ptr holds.
- Outputs (combinational from the FIFO heads):
  - wr_unlock_en_o = |req.
  - wr_unlock_addr_o / wr_unlock_data_o come from the granted head, and are '0 when no request.
- Latency: a result accepted at edge N appears on wr_unlock_* in cycle N+1 at the earliest. The regfile updates at edge N+1.
- Throughput: one writeback per cycle in aggregate. Each source is guaranteed one slot per NS cycles under full contention.
- Ordering:
  - FIFO order within a source.
  - No ordering across sources. The issue stage never has two in-flight writers to the same rd, so cross-source write-after-write cannot occur.

Optional Feature:
- Macro MAVERICKONE_WB_BYPASS_EN.
- When defined:
  - A source whose FIFO is empty and which presents valid with nonzero addr joins arbitration in the same cycle, with its input as the head.
  - If granted, the result is not stored (no push, no pop), giving zero-cycle latency.
  - If not granted, it is pushed normally.
  - src_ready_o is unchanged.
- When undefined: behaviour as above, minimum latency 1 cycle.

Decomposition:
- maverickOne_pkg adds:
  - WB_NUM_SRC (4) and WB_FIFO_DEPTH (2).
  - typedef wb_req_t, a struct with addr (AW bits) and data (XLEN bits).
- Sub-module maverickOne_wb_fifo: parameterised depth, push/pop/count/head. It is instantiated NS times.
- Round-robin grant logic stays in the top module.

Test Plan:
- Reset, then idle: all outputs 0.
  - Assert arst_i for 3 cycles mid-stream: pending_o drops to 0 immediately and buffered results are never emitted.
- Single source: src0 sends rd=5, data=0xDEAD_BEEF at edge N.
  - Cycle N+1: en=1, addr=5, data=0xDEAD_BEEF. Cycle N+2: en=0.
- Contention: all 4 sources push rd=1..4 in the same cycle with rr_ptr=0.
  - Writebacks appear on 4 consecutive cycles in order 1,2,3,4.
  - Next, sources 0 and 2 push: order is 1 then 3, with rr_ptr=... starting at 0 after wrap.
- Backpressure: src1 pushes 3 results in consecutive cycles while higher-priority sources hold the grant.
  - src_ready_o[1]=0 after 2 stored.
  - The third transfer completes only after a pop. No data is lost or reordered.
- x0 filter: src3 sends rd=0 with data=0x1234, accepted with ready=1.
  - wr_unlock_en_o never asserts for it, and pending_o[3] stays 0.
- With MAVERICKONE_WB_BYPASS_EN: idle block, src2 valid with rd=7.
  - en=1, addr=7 in the same cycle.
  - count[2] stays 0.
